// File: rtl/approx_mul_seq_pkg.sv
// Shared definitions for the approximate sequential multiplier.
// Holds the controller state encoding, operand width, last accumulation
// step and the helpers that place the output window inside the 33-bit sum.
package approx_mul_seq_pkg;

    localparam int W    = 16;
    localparam int KMAX = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Upper bit index of the output window for half-width n.
    function automatic int win_hi(input int n);
        return 16 + n;
    endfunction

    // Lower bit index of the output window for half-width n.
    function automatic int win_lo(input int n);
        return 16 - n;
    endfunction

endpackage

// File: rtl/approx_mul_seq_fs_window_add.sv
// fs_window_add: final carry-keeping add of the two partial-product
// accumulators followed by extraction of the output window.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - capture the new window into the output register
//   s0, s1    - 32-bit even-step and odd-step accumulators
//   win       - registered window, bits [16+N:16-N] of s0+s1
module fs_window_add
    import approx_mul_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [31:0]   s0,
    input  logic [31:0]   s1,
    output logic [2*N:0]  win
);

    localparam int LO = win_lo(N);
    localparam int ZW = win_hi(N) - win_lo(N) + 1;

    logic [32:0]   sum_s;
    logic [ZW-1:0] win_s;
    logic [ZW-1:0] win_r;

    // Exact 33-bit sum, then keep only the window starting at LO.
    always_comb begin
        sum_s = {1'b0, s0} + {1'b0, s1};
        win_s = ZW'(sum_s >> LO);
    end

    // Window register: loaded once per operation, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_r <= '0;
        end else if (load) begin
            win_r <= win_s;
        end else begin
            win_r <= win_r;
        end
    end

    assign win = win_r;

endmodule

// File: rtl/approx_mul_seq.sv
// approx_mul_seq: 16x16 unsigned shift-and-add multiplier returning a
// (2N+1)-bit window of the product centred on bit 16.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid/in_ready   - operand handshake for a, b
//   a, b                - unsigned multiplicand / multiplier
//   out_valid/out_ready - result handshake for z
//   z                   - window bits [16+N:16-N] of the product
//   busy                - high whenever the controller is not idle
//   k                   - current accumulation step
module approx_mul_seq #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2*N:0]  z,
    output logic          busy,
    output logic [4:0]    k
);

    import approx_mul_seq_pkg::*;

    state_t       state_r;
    state_t       state_s;
    logic         in_ready_s;
    logic         accept_s;
    logic         load_s;
    logic         out_valid_r;
    logic         busy_r;
    logic [4:0]   k_r;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [31:0]  s0_r;
    logic [31:0]  s1_r;
    logic [31:0]  addend_s;

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s == DONE);
            busy_r      <= (state_s != IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = ACCUM;
                else          state_s = IDLE;
            end
            ACCUM: begin
                if (k_r == 5'(KMAX)) state_s = ADD;
                else                 state_s = ACCUM;
            end
            ADD: begin
                state_s = DONE;
            end
            DONE: begin
                // Back-to-back accept skips IDLE entirely.
                if (out_ready) begin
                    if (in_valid) state_s = ACCUM;
                    else          state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake and load decode from the current state.
    always_comb begin
        in_ready_s = 1'b0;
        load_s     = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            DONE:    in_ready_s = out_ready;
            ADD:     load_s     = 1'b1;
            default: in_ready_s = 1'b0;
        endcase
        accept_s = in_valid && in_ready_s;
    end

    // Shifted multiplicand for the current step; never exceeds 32 bits.
    assign addend_s = 32'(a_r) << k_r[3:0];

    // Operand capture, step counter and split accumulators.  Even steps go
    // to S0 and odd steps to S1 so each accumulator stays within 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= '0;
            b_r  <= '0;
            s0_r <= 32'd0;
            s1_r <= 32'd0;
            k_r  <= 5'd0;
        end else if (accept_s) begin
            a_r  <= a;
            b_r  <= b;
            s0_r <= 32'd0;
            s1_r <= 32'd0;
            k_r  <= 5'd0;
        end else if (state_r == ACCUM) begin
            if (b_r[k_r[3:0]]) begin
                if (k_r[0]) s1_r <= s1_r + addend_s;
                else        s0_r <= s0_r + addend_s;
            end else begin
                s0_r <= s0_r;
                s1_r <= s1_r;
            end
            // k stops at the last step and holds through ADD and DONE.
            if (k_r != 5'(KMAX)) k_r <= k_r + 5'd1;
            else                 k_r <= k_r;
        end else begin
            k_r <= k_r;
        end
    end

    fs_window_add #(
        .N (N)
    ) u_fs_window_add (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .s0   (s0_r),
        .s1   (s1_r),
        .win  (z)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign k         = k_r;

endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed testbench for approx_mul_seq: an N=4 and an N=16 instance share
// every input so the same stimulus checks both window widths.
module tb_approx_mul_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;

    logic        in_ready4, out_valid4, busy4;
    logic [8:0]  z4;
    logic [4:0]  k4;
    logic        in_ready16, out_valid16, busy16;
    logic [32:0] z16;
    logic [4:0]  k16;

    int total = 0;
    int bad   = 0;

    approx_mul_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
        .z(z4), .busy(busy4), .k(k4)
    );

    approx_mul_seq #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a), .b(b), .out_valid(out_valid16), .out_ready(out_ready),
        .z(z16), .busy(busy16), .k(k16)
    );

    always #5 clk = ~clk;

    // Offer a pair at #1 after an edge; rdy is in_ready seen before the capture edge.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, output logic rdy);
        in_valid = 1'b1;
        a = av;
        b = bv;
        rdy = in_ready4;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait after the capture edge; lat counts edges including the capture edge.
    task automatic wait_done(output int lat, output int busy_low);
        lat = 1;
        busy_low = 0;
        while (out_valid4 !== 1'b1 && lat < 40) begin
            if (busy4 !== 1'b1) busy_low++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy4); end
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready4); end
        total++; if (z4 !== 9'h000) begin bad++; $display("FAIL reset_z got=%h want=000", z4); end
        total++; if (k4 !== 5'd0) begin bad++; $display("FAIL reset_k got=%0d want=0", k4); end
        total++; if (z16 !== 33'h0) begin bad++; $display("FAIL reset_z16 got=%h want=0", z16); end
    endtask

    task automatic test_basic();
        logic rdy;
        int lat, bl;
        start_op(16'h00FF, 16'h0100, rdy);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b want=1", rdy); end
        wait_done(lat, bl);
        total++; if (lat != 18) begin bad++; $display("FAIL basic_latency got=%0d want=18", lat); end
        total++; if (z4 !== 9'h00F) begin bad++; $display("FAIL basic_z got=%h want=00f", z4); end
        total++; if (z16 !== 33'h00000FF00) begin bad++; $display("FAIL basic_z16 got=%h want=00000ff00", z16); end
        total++; if (out_valid16 !== 1'b1) begin bad++; $display("FAIL basic_out_valid16 got=%b want=1", out_valid16); end
        @(posedge clk); #1;
        total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL basic_drop_valid got=%b want=0", out_valid4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", busy4); end
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b want=1", in_ready4); end
    endtask

    task automatic test_max();
        logic rdy;
        int lat, bl;
        start_op(16'hFFFF, 16'hFFFF, rdy);
        wait_done(lat, bl);
        total++; if (lat != 18) begin bad++; $display("FAIL max_latency got=%0d want=18", lat); end
        total++; if (z4 !== 9'h1E0) begin bad++; $display("FAIL max_z got=%h want=1e0", z4); end
        total++; if (z16 !== 33'h0FFFE0001) begin bad++; $display("FAIL max_z16 got=%h want=0fffe0001", z16); end
        total++; if (k4 !== 5'd15) begin bad++; $display("FAIL max_k_done got=%0d want=15", k4); end
        @(posedge clk); #1;
    endtask

    // Small product underflows the window; in_valid during the run is ignored.
    task automatic test_small();
        logic rdy;
        int lat, bl;
        start_op(16'd3, 16'd5, rdy);
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        wait_done(lat, bl);
        in_valid = 1'b0;
        total++; if (lat != 18) begin bad++; $display("FAIL small_latency got=%0d want=18", lat); end
        total++; if (bl != 0) begin bad++; $display("FAIL small_busy_low got=%0d want=0", bl); end
        total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL small_busy_done got=%b want=1", busy4); end
        total++; if (z4 !== 9'h000) begin bad++; $display("FAIL small_z got=%h want=000", z4); end
        total++; if (z16 !== 33'h00000000F) begin bad++; $display("FAIL small_z16 got=%h want=00000000f", z16); end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        logic rdy;
        int lat, bl;
        start_op(16'h0000, 16'h1234, rdy);
        wait_done(lat, bl);
        total++; if (lat != 18) begin bad++; $display("FAIL zero_latency got=%0d want=18", lat); end
        total++; if (z4 !== 9'h000 || z16 !== 33'h0) begin bad++; $display("FAIL zero_z got=%h/%h want=0/0", z4, z16); end
        @(posedge clk); #1;
    endtask

    // Stall in DONE, then accept the next pair in the same cycle out_ready rises.
    task automatic test_back_to_back();
        logic rdy;
        int lat, bl;
        start_op(16'h1234, 16'h5678, rdy);
        out_ready = 1'b0;
        wait_done(lat, bl);
        total++; if (z4 !== 9'h060) begin bad++; $display("FAIL b2b_first_z got=%h want=060", z4); end
        total++; if (z16 !== 33'h006260060) begin bad++; $display("FAIL b2b_first_z16 got=%h want=006260060", z16); end
        in_valid = 1'b1;
        a = 16'h00FF;
        b = 16'h0100;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid4 !== 1'b1 || z4 !== 9'h060 || in_ready4 !== 1'b0) begin
                bad++;
                $display("FAIL b2b_stall cyc=%0d got v=%b z=%h rdy=%b want v=1 z=060 rdy=0", i, out_valid4, z4, in_ready4);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", in_ready4); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid4 !== 1'b0 || busy4 !== 1'b1 || k4 !== 5'd0) begin
            bad++; $display("FAIL b2b_accept got v=%b busy=%b k=%0d want v=0 busy=1 k=0", out_valid4, busy4, k4);
        end
        wait_done(lat, bl);
        total++; if (lat != 18) begin bad++; $display("FAIL b2b_latency got=%0d want=18", lat); end
        total++; if (z4 !== 9'h00F) begin bad++; $display("FAIL b2b_second_z got=%h want=00f", z4); end
        @(posedge clk); #1;
    endtask

    // Reset at k=7 abandons the run; reset also beats a same-cycle handshake.
    task automatic test_reset_mid();
        logic rdy;
        int n;
        int lat, bl;
        start_op(16'hFFFF, 16'hFFFF, rdy);
        n = 0;
        while (k4 !== 5'd7 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (k4 !== 5'd7) begin bad++; $display("FAIL rmid_reach_k got=%0d want=7", k4); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || z4 !== 9'h000 || k4 !== 5'd0) begin
            bad++; $display("FAIL rmid_abandon got v=%b busy=%b z=%h k=%0d want 0 0 000 0", out_valid4, busy4, z4, k4);
        end
        total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", in_ready4); end
        in_valid = 1'b1;
        a = 16'd5;
        b = 16'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL rst_priority_busy got=%b want=0", busy4); end
        start_op(16'd2, 16'd2, rdy);
        wait_done(lat, bl);
        total++; if (lat != 18) begin bad++; $display("FAIL rmid_latency got=%0d want=18", lat); end
        total++; if (z4 !== 9'h000) begin bad++; $display("FAIL rmid_z got=%h want=000", z4); end
        total++; if (z16 !== 33'h000000004) begin bad++; $display("FAIL rmid_z16 got=%h want=000000004", z16); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_small();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
